// File: rtl/oam_dma.sv
// oam_dma: sprite-attribute DMA engine.
//
// A CPU write to 16'h4014 in IDLE latches a source page and halts the CPU.
// The engine then copies 256 bytes from {page, 8'h00}..{page, 8'hFF} to the
// fixed sink address 16'h2004. Each byte takes one READ cycle and one WRITE cycle.
//
// Optional feature, selected by macro OAM_DMA_ODD_ALIGN_EN:
//   When the macro is defined, a free-running parity toggle exists. A HALT
//   cycle entered on odd parity inserts one extra ALIGN cycle before the
//   first READ. When the macro is undefined, HALT always goes straight to READ.
//
// Ports:
//   clk_ph1      in   system clock, rising-edge active
//   rst          in   asynchronous active-low reset
//   cpu_addr     in   CPU address bus [15:0]
//   cpu_data_out in   CPU write data [7:0]
//   cpu_we       in   CPU write strobe
//   bus_data_in  in   memory read data for dma_addr [7:0]
//   cpu_rdy      out  1 = CPU may advance (IDLE only)
//   dma_active   out  1 = DMA owns the bus (any non-IDLE state)
//   dma_addr     out  DMA bus address [15:0]
//   dma_data_out out  byte captured in the last READ [7:0]
//   dma_we       out  DMA write strobe (WRITE only)
module oam_dma (
    input  logic        clk_ph1,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_we,
    input  logic [7:0]  bus_data_in,
    output logic        cpu_rdy,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_data_out,
    output logic        dma_we
);

    localparam logic [15:0] TrigAddr = 16'h4014;
    localparam logic [15:0] SinkAddr = 16'h2004;

    typedef enum logic [2:0] {
        StIdle,
        StHalt,
        StAlign,
        StRead,
        StWrite
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;
    logic       trigger;

    assign trigger = cpu_we && (cpu_addr == TrigAddr);

`ifdef OAM_DMA_ODD_ALIGN_EN
    logic parity_q;

    // Free-running cycle parity. It is not gated by state.
    always_ff @(posedge clk_ph1 or negedge rst) begin
        if (!rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ~parity_q;
        end
    end
`endif

    always_ff @(posedge clk_ph1 or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            page_q  <= 8'h00;
            idx_q   <= 8'h00;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        idx_d      = idx_q;
        data_d     = data_q;
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
        dma_addr   = 16'h0000;
        dma_we     = 1'b0;

        case (state_q)
            StIdle: begin
                cpu_rdy    = 1'b1;
                dma_active = 1'b0;
                if (trigger) begin
                    state_d = StHalt;
                    page_d  = cpu_data_out;
                    idx_d   = 8'h00;
                end
            end
            StHalt: begin
`ifdef OAM_DMA_ODD_ALIGN_EN
                state_d = parity_q ? StAlign : StRead;
`else
                state_d = StRead;
`endif
            end
`ifdef OAM_DMA_ODD_ALIGN_EN
            StAlign: begin
                state_d = StRead;
            end
`endif
            StRead: begin
                // idx stays 8 bits wide, so the address never carries into the page byte.
                dma_addr = {page_q, idx_q};
                data_d   = bus_data_in;
                state_d  = StWrite;
            end
            StWrite: begin
                dma_addr = SinkAddr;
                dma_we   = 1'b1;
                idx_d    = idx_q + 8'd1;
                state_d  = (idx_q == 8'hFF) ? StIdle : StRead;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign dma_data_out = data_q;

endmodule

// File: tb/tb_oam_dma.sv
module tb_oam_dma;

    logic        clk_ph1;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_we;
    logic [7:0]  bus_data_in;
    logic        cpu_rdy;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic [7:0]  dma_data_out;
    logic        dma_we;

    int tests = 0;
    int fails = 0;

    // Monitor state
    int          halt_cnt = 0;
    int          wr_cnt = 0;
    int          bad_wr = 0;
    int          pcyc = 0;
    logic [15:0] prev_addr = 16'h0000;
    logic [7:0]  wr_data [4096];
    logic [15:0] rd_addr [4096];

    oam_dma dut (
        .clk_ph1     (clk_ph1),
        .rst         (rst),
        .cpu_addr    (cpu_addr),
        .cpu_data_out(cpu_data_out),
        .cpu_we      (cpu_we),
        .bus_data_in (bus_data_in),
        .cpu_rdy     (cpu_rdy),
        .dma_active  (dma_active),
        .dma_addr    (dma_addr),
        .dma_data_out(dma_data_out),
        .dma_we      (dma_we)
    );

    // Memory model
    assign bus_data_in = dma_addr[7:0] ^ 8'hA5;

    initial clk_ph1 = 1'b0;
    always #5 clk_ph1 = ~clk_ph1;

    // Reference parity: number of clock edges since reset release.
    always @(posedge clk_ph1 or negedge rst) begin
        if (!rst) pcyc <= 0;
        else      pcyc <= pcyc + 1;
    end

    // A write cycle always follows its read cycle, so the address of the
    // previous cycle is the source of each written byte.
    always @(negedge clk_ph1) begin
        if (cpu_rdy === 1'b0) halt_cnt = halt_cnt + 1;
        if (dma_we === 1'b1) begin
            wr_data[wr_cnt] = dma_data_out;
            rd_addr[wr_cnt] = prev_addr;
            if (dma_addr !== 16'h2004) bad_wr = bad_wr + 1;
            wr_cnt = wr_cnt + 1;
        end
        prev_addr = dma_addr;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_ph1);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_xfer(input logic [7:0] page, input bit want_par, input int inject_at,
                            input string tag);
        int          n;
        int          base;
        int          hbase;
        int          wbase;
        int          exp_halt;
        int          seq_err;
        bit          prev_we;
        logic [15:0] exp2;
        exp_halt = 513;
        exp2     = {page, 8'h00};
`ifdef OAM_DMA_ODD_ALIGN_EN
        if (want_par) begin
            exp_halt = 514;
            exp2     = 16'h0000;
        end
`endif
        // Parity flips on the trigger edge, so wait for its complement.
        while (pcyc[0] == want_par) step();
        base  = wr_cnt;
        hbase = halt_cnt;
        wbase = bad_wr;
        cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_data_out = page;
        step();
        cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_data_out = 8'h00;
        check({tag, ".halt_rdy"}, 32'(cpu_rdy), 32'd0);
        check({tag, ".halt_addr"}, 32'(dma_addr), 32'h0000);
        step();
        check({tag, ".cyc2_addr"}, 32'(dma_addr), 32'(exp2));
        check({tag, ".cyc2_we"}, 32'(dma_we), 32'd0);
        n = 2;
        prev_we = dma_we;
        while (!cpu_rdy && n < 600) begin
            if (n == inject_at) begin
                cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_data_out = 8'h07;
            end
            prev_we = dma_we;
            step();
            cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_data_out = 8'h00;
            n++;
        end
        check({tag, ".done"}, 32'(cpu_rdy), 32'd1);
        check({tag, ".halt_len"}, 32'(halt_cnt - hbase), 32'(exp_halt));
        check({tag, ".writes"}, 32'(wr_cnt - base), 32'd256);
        check({tag, ".first_rd"}, 32'(rd_addr[base]), 32'({page, 8'h00}));
        check({tag, ".last_rd"}, 32'(rd_addr[base + 255]), 32'({page, 8'hFF}));
        seq_err = 0;
        for (int k = 0; k < 256; k++) begin
            if (rd_addr[base + k] !== {page, 8'(k)}) seq_err++;
        end
        check({tag, ".rd_seq"}, 32'(seq_err), 32'd0);
        check({tag, ".wr_addr"}, 32'(bad_wr - wbase), 32'd0);
        check({tag, ".rdy_after_wr"}, 32'(prev_we), 32'd1);
    endtask

    initial begin
        int b;
        int err;
        rst = 1'b0;
        cpu_addr = 16'h0000;
        cpu_data_out = 8'h00;
        cpu_we = 1'b0;
        #3;
        check("rst.rdy", 32'(cpu_rdy), 32'd1);
        check("rst.active", 32'(dma_active), 32'd0);
        check("rst.we", 32'(dma_we), 32'd0);
        check("rst.addr", 32'(dma_addr), 32'h0);
        check("rst.data", 32'(dma_data_out), 32'h0);
        repeat (2) @(posedge clk_ph1);
        #1 rst = 1'b1;
        step();

        // Non-trigger accesses
        cpu_we = 1'b1; cpu_addr = 16'h4015; cpu_data_out = 8'h09;
        step();
        check("nt4015.rdy", 32'(cpu_rdy), 32'd1);
        check("nt4015.active", 32'(dma_active), 32'd0);
        cpu_we = 1'b0; cpu_addr = 16'h4014;
        step();
        check("ntwe0.rdy", 32'(cpu_rdy), 32'd1);
        cpu_addr = 16'h0000; cpu_data_out = 8'h00;

        run_xfer(8'h02, 1'b0, -1, "p02");

        b = wr_cnt;
        run_xfer(8'h03, 1'b1, -1, "p03");
        err = 0;
        for (int k = 0; k < 256; k++) begin
            if (wr_data[b + k] !== (8'(k) ^ 8'hA5)) err++;
        end
        check("p03.data_seq", 32'(err), 32'd0);
        check("p03.data_first", 32'(wr_data[b]), 32'hA5);
        check("p03.data_last", 32'(wr_data[b + 255]), 32'h5A);
        check("p03.idle_hold", 32'(dma_data_out), 32'h5A);
        check("p03.idle_addr", 32'(dma_addr), 32'h0000);

        run_xfer(8'hFF, 1'b0, -1, "pFF");

        run_xfer(8'h06, 1'b0, 50, "p06");
        repeat (3) step();
        check("p06.no_retrig_rdy", 32'(cpu_rdy), 32'd1);
        check("p06.no_retrig_active", 32'(dma_active), 32'd0);

        // Reset in the middle of a transfer
        while (pcyc[0] != 1'b1) step();
        cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_data_out = 8'h05;
        step();
        cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_data_out = 8'h00;
        repeat (99) step();
        check("p05.mid_busy", 32'(cpu_rdy), 32'd0);
        #2 rst = 1'b0;
        #1;
        check("abort.rdy", 32'(cpu_rdy), 32'd1);
        check("abort.active", 32'(dma_active), 32'd0);
        check("abort.we", 32'(dma_we), 32'd0);
        check("abort.addr", 32'(dma_addr), 32'h0000);
        check("abort.data", 32'(dma_data_out), 32'h00);
        b = wr_cnt;
        repeat (3) @(posedge clk_ph1);
        #1 rst = 1'b1;
        repeat (3) step();
        check("abort.no_writes", 32'(wr_cnt - b), 32'd0);
        check("abort.idle", 32'(cpu_rdy), 32'd1);
        run_xfer(8'h04, 1'b0, -1, "p04");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 clk_ph1  in  1  single system clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-low.
REQ-003 cpu_addr  in  16  CPU address bus.
REQ-004 cpu_data_out  in  8  CPU write data.
REQ-005 cpu_we  in  1  CPU write strobe, valid in the same cycle as cpu_addr.
REQ-006 bus_data_in  in  8  read data returned combinationally by memory for dma_addr.
REQ-007 cpu_rdy  out  1  1 = CPU may advance; 0 = CPU halted.
REQ-008 dma_active  out  1  1 = DMA owns the system bus.
REQ-009 dma_addr  out  16  DMA bus address.
REQ-010 dma_data_out  out  8  DMA write data.
REQ-011 dma_we  out  1  DMA write strobe.

Function
REQ-012 Trigger: cpu_we=1 and cpu_addr=16'h4014 while in IDLE; the page register latches cpu_data_out at that edge.
REQ-013 A trigger condition in any non-IDLE state is ignored.
REQ-014 States: IDLE, HALT, ALIGN, READ, WRITE.
REQ-015 Transitions: IDLE->HALT on trigger; HALT->ALIGN when parity=1, else HALT->READ; ALIGN->READ; READ->WRITE; WRITE->READ while idx!=8'hFF; WRITE->IDLE when idx=8'hFF.
REQ-016 parity is a 1-bit toggle that flips every clock from reset; its reset value is 0.
REQ-017 cpu_rdy=1 only in IDLE; dma_active=1 in every non-IDLE state; both are decoded from the state register.
REQ-018 HALT and ALIGN: no bus activity; dma_we=0, dma_addr=16'h0000.
REQ-019 READ: dma_addr={page,idx}, dma_we=0; bus_data_in is captured into dma_data_out at the edge that ends READ.
REQ-020 WRITE: dma_addr=16'h2004, dma_we=1, dma_data_out holds the byte captured in the preceding READ; idx increments by 1 at the edge that ends WRITE.
REQ-021 idx is 8 bits and wraps from 8'hFF to 8'h00; the address never carries into the page byte (page FF reads FF00..FFFF only).
REQ-022 In IDLE: dma_addr=16'h0000, dma_we=0, dma_data_out holds its last value.
REQ-023 Halted length: 513 cycles with parity=0 at HALT (1 HALT + 256 READ/WRITE pairs); 514 cycles with parity=1 (adds ALIGN).
REQ-024 cpu_rdy returns to 1 in the cycle after the final WRITE.

Reset
REQ-025 rst=0 asynchronously forces: state=IDLE, idx=0, page=0, parity=0, dma_data_out=0, cpu_rdy=1, dma_active=0, dma_we=0, dma_addr=0.
REQ-026 Reset mid-transfer aborts the transfer with no further writes; the first trigger after release starts at idx=0.

Configuration
REQ-027 Macro OAM_DMA_ODD_ALIGN_EN defined: the ALIGN state and parity logic exist exactly as specified in REQ-015/016/023.
REQ-028 Macro OAM_DMA_ODD_ALIGN_EN undefined: HALT->READ always; parity logic and the ALIGN state are not synthesized; the halt is always 513 cycles.

Verification
REQ-029 parity=0, write 8'h02 to 4014 -> cpu_rdy=0 for exactly 513 cycles; first READ addr 0200, last READ addr 02FF; 256 WRITEs to 2004.
REQ-030 Macro defined, trigger timed so parity=1 at HALT -> 514-cycle halt; ALIGN cycle has dma_we=0; macro undefined with the same timing -> 513 cycles.
REQ-031 Memory model returns (addr[7:0]^8'hA5), page 8'h03 -> 256 WRITEs carry data A5,A4,...,5A in idx order.
REQ-032 Page 8'hFF -> last READ addr FFFF; no access to 0000; cpu_rdy=1 one cycle after the final WRITE.
REQ-033 rst pulsed low at transfer cycle 100 -> cpu_rdy=1 and dma_active=0 immediately without waiting for a clock; a new trigger with page 8'h04 starts at 0400.
REQ-034 Non-trigger accesses (write to 4015, cpu_we=0 with addr 4014) and a second 4014 write issued mid-transfer -> no new transfer started; the ongoing transfer is unchanged.
